// File: rtl/cpu8_pkg.sv
// ============================================================================
// cpu8_pkg : shared widths, address type and dump FSM state encoding for the
//            8-bit CPU register file.   Rev 1.0
// ============================================================================
`default_nettype none

package cpu8_pkg;

  localparam int DATA_W     = 8;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } dump_state_t;

endpackage

`default_nettype wire

// File: rtl/mux32to1nbit.sv
// ============================================================================
// mux32to1nbit : 32-way N-bit combinational selector.   Rev 1.0
// ============================================================================
`default_nettype none

module mux32to1nbit #(
  parameter int N = 8
) (
  input  logic [31:0][N-1:0] d_in,
  input  logic [4:0]         sel,
  output logic [N-1:0]       y
);

  assign y = d_in[sel];

endmodule

`default_nettype wire

// File: rtl/reg_file_32x8.sv
// ============================================================================
// reg_file_32x8 : 32x8 register bank, 1 write / 2 read ports plus a
//                 valid/ready register dump engine.
// Optional macro: REGFILE_BYPASS_EN (write-to-read forwarding on A/B).
// Rev 1.0
// ============================================================================
`default_nettype none

module reg_file_32x8
  import cpu8_pkg::*;
#(
  parameter int N        = DATA_W,
  parameter int NUM_REGS = cpu8_pkg::NUM_REGS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [REG_ADDR_W-1:0] waddr,
  input  logic [N-1:0]          wdata,
  input  logic [REG_ADDR_W-1:0] raddr_a,
  input  logic [REG_ADDR_W-1:0] raddr_b,
  output logic [N-1:0]          rdata_a,
  output logic [N-1:0]          rdata_b,
  input  logic                  dump_start,
  input  logic                  dump_ready,
  output logic                  dump_valid,
  output logic [REG_ADDR_W-1:0] dump_addr,
  output logic [N-1:0]          dump_data,
  output logic                  dump_busy,
  output logic                  dump_done
);

  localparam reg_addr_t LAST_IDX = reg_addr_t'(NUM_REGS - 1);

  logic [NUM_REGS-1:0][N-1:0] regs_q, regs_d;
  dump_state_t                state_q, state_d;
  reg_addr_t                  ptr_q, ptr_d;

  logic [N-1:0] mux_a, mux_b;

  // Storage and write decode
  always_comb begin
    regs_d = regs_q;
    if (we) begin
      regs_d[waddr] = wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      regs_q  <= '0;
      state_q <= IDLE;
      ptr_q   <= '0;
    end else begin
      regs_q  <= regs_d;
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  mux32to1nbit #(.N(N)) u_mux_a (
    .d_in (regs_q),
    .sel  (raddr_a),
    .y    (mux_a)
  );

  mux32to1nbit #(.N(N)) u_mux_b (
    .d_in (regs_q),
    .sel  (raddr_b),
    .y    (mux_b)
  );

  // Dump beats always show the registered contents, never forwarded data
  mux32to1nbit #(.N(N)) u_mux_dump (
    .d_in (regs_q),
    .sel  (ptr_q),
    .y    (dump_data)
  );

`ifdef REGFILE_BYPASS_EN
  assign rdata_a = (we && (waddr == raddr_a)) ? wdata : mux_a;
  assign rdata_b = (we && (waddr == raddr_b)) ? wdata : mux_b;
`else
  assign rdata_a = mux_a;
  assign rdata_b = mux_b;
`endif

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    dump_valid = 1'b0;
    dump_busy  = 1'b0;
    dump_done  = 1'b0;
    case (state_q)
      IDLE: begin
        if (dump_start) begin
          state_d = SCAN;
          ptr_d   = '0;
        end
      end
      SCAN: begin
        dump_valid = 1'b1;
        dump_busy  = 1'b1;
        if (dump_ready) begin
          if (ptr_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            ptr_d = ptr_q + reg_addr_t'(1);
          end
        end
      end
      DONE: begin
        dump_busy = 1'b1;
        dump_done = 1'b1;
        state_d   = IDLE;
        ptr_d     = '0;
      end
      default: begin
        state_d = IDLE;
        ptr_d   = '0;
      end
    endcase
  end

  assign dump_addr = ptr_q;

endmodule

`default_nettype wire

// File: tb/tb_reg_file_32x8.sv
// ============================================================================
// tb_reg_file_32x8 : randomized self-checking bench for reg_file_32x8 against
//                    an array/queue reference model.   Rev 1.0
// ============================================================================
`default_nettype none

module tb_reg_file_32x8;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       we = 1'b0;
  logic [4:0] waddr = '0;
  logic [7:0] wdata = '0;
  logic [4:0] raddr_a = '0;
  logic [4:0] raddr_b = '0;
  logic [7:0] rdata_a, rdata_b;
  logic       dump_start = 1'b0;
  logic       dump_ready = 1'b0;
  logic       dump_valid;
  logic [4:0] dump_addr;
  logic [7:0] dump_data;
  logic       dump_busy;
  logic       dump_done;

  int vectors    = 0;
  int miscompares = 0;
  logic [7:0] model [32];

  always #5 clk = ~clk;

  reg_file_32x8 dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .we         (we),
    .waddr      (waddr),
    .wdata      (wdata),
    .raddr_a    (raddr_a),
    .raddr_b    (raddr_b),
    .rdata_a    (rdata_a),
    .rdata_b    (rdata_b),
    .dump_start (dump_start),
    .dump_ready (dump_ready),
    .dump_valid (dump_valid),
    .dump_addr  (dump_addr),
    .dump_data  (dump_data),
    .dump_busy  (dump_busy),
    .dump_done  (dump_done)
  );

  // Advance one clock, applying the edge's effect to the reference array
  task automatic clk_step();
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) model[i] = 8'h00;
    end else if (we) begin
      model[waddr] = wdata;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    we = 1'b1;
    for (int i = 0; i < 32; i++) begin
      waddr = 5'(i);
      wdata = 8'hFF;
      clk_step();
    end
    we = 1'b0;
    rst_n = 1'b0;
    clk_step();
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      raddr_a = 5'(i);
      raddr_b = 5'(31 - i);
      #1;
      vectors++;
      if (rdata_a !== 8'h00 || rdata_b !== 8'h00) begin
        miscompares++;
        $display("FAIL reset_read reg%0d: got a=%h b=%h want 00", i, rdata_a, rdata_b);
      end
    end
    vectors++;
    if (dump_busy !== 1'b0 || dump_valid !== 1'b0 || dump_done !== 1'b0 || dump_addr !== 5'd0) begin
      miscompares++;
      $display("FAIL reset_dump: got busy=%b valid=%b done=%b addr=%0d want 0/0/0/0",
               dump_busy, dump_valid, dump_done, dump_addr);
    end
  endtask

  task automatic test_write_read();
    we = 1'b1; waddr = 5'd5; wdata = 8'hA5;
    clk_step();
    we = 1'b0;
    raddr_a = 5'd5; raddr_b = 5'd5;
    #1;
    vectors++;
    if (rdata_a !== 8'hA5 || rdata_b !== 8'hA5) begin
      miscompares++;
      $display("FAIL write_read: got a=%h b=%h want a5", rdata_a, rdata_b);
    end
    raddr_a = 5'd6;
    #1;
    vectors++;
    if (rdata_a !== 8'h00) begin
      miscompares++;
      $display("FAIL read_unwritten: got %h want 00", rdata_a);
    end
  endtask

  task automatic test_same_cycle();
    logic [7:0] exp;
    we = 1'b1; waddr = 5'd3; wdata = 8'h11;
    clk_step();
    wdata = 8'h22;
    raddr_a = 5'd3; raddr_b = 5'd3;
    #1;
    exp = BYP ? 8'h22 : 8'h11;
    vectors++;
    if (rdata_a !== exp || rdata_b !== exp) begin
      miscompares++;
      $display("FAIL same_cycle: got a=%h b=%h want %h", rdata_a, rdata_b, exp);
    end
    clk_step();
    we = 1'b0;
    #1;
    vectors++;
    if (rdata_a !== 8'h22 || rdata_b !== 8'h22) begin
      miscompares++;
      $display("FAIL after_write: got a=%h b=%h want 22", rdata_a, rdata_b);
    end
  endtask

  task automatic test_dump();
    int beats = 0;
    int dones = 0;
    int cycles = -1;
    we = 1'b1;
    for (int i = 0; i < 32; i++) begin
      waddr = 5'(i);
      wdata = 8'(i * 3);
      clk_step();
    end
    we = 1'b0;
    dump_ready = 1'b1;
    dump_start = 1'b1;
    clk_step();
    dump_start = 1'b0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (!dump_busy) begin
        cycles = c;
        break;
      end
      if (dump_valid) begin
        vectors++;
        if (dump_addr !== 5'(beats) || dump_data !== 8'(beats * 3)) begin
          miscompares++;
          $display("FAIL dump_beat%0d: got addr=%0d data=%h want addr=%0d data=%h",
                   beats, dump_addr, dump_data, beats, 8'(beats * 3));
        end
        beats++;
      end
      if (dump_done) dones++;
      clk_step();
    end
    vectors++;
    if (beats != 32 || dones != 1 || cycles != 33) begin
      miscompares++;
      $display("FAIL dump_totals: got beats=%0d dones=%0d cycles=%0d want 32/1/33",
               beats, dones, cycles);
    end
  endtask

  task automatic test_backpressure();
    int  exp_idx = 0;
    int  dones = 0;
    bit  finished = 1'b0;
    for (int i = 0; i < 32; i++) begin
      we = 1'b1; waddr = 5'(i); wdata = 8'($urandom);
      clk_step();
    end
    we = 1'b0;
    dump_start = 1'b1;
    clk_step();
    dump_start = 1'b0;
    for (int cyc = 0; cyc < 300; cyc++) begin
      dump_ready = (cyc % 2) == 0;
      dump_start = (cyc == 7) || (cyc == 20);
      we = 1'b0;
      if (!dump_ready && exp_idx < 32) begin
        we = 1'b1; waddr = 5'(exp_idx); wdata = 8'($urandom);
      end else if ($urandom_range(1, 0) == 1) begin
        we = 1'b1; waddr = 5'($urandom); wdata = 8'($urandom);
      end
      #1;
      if (dump_valid) begin
        vectors++;
        if (exp_idx > 31 || dump_addr !== 5'(exp_idx) || dump_data !== model[exp_idx[4:0]]) begin
          miscompares++;
          $display("FAIL bp_beat%0d: got addr=%0d data=%h want addr=%0d data=%h",
                   exp_idx, dump_addr, dump_data, exp_idx, model[exp_idx[4:0]]);
        end
        if (dump_ready) exp_idx++;
      end
      if (dump_done) begin
        dones++;
        finished = 1'b1;
        clk_step();
        break;
      end
      clk_step();
    end
    dump_start = 1'b0;
    we = 1'b0;
    dump_ready = 1'b1;
    vectors++;
    if (!finished || exp_idx != 32 || dones != 1) begin
      miscompares++;
      $display("FAIL bp_totals: got finished=%0b beats=%0d dones=%0d want 1/32/1",
               finished, exp_idx, dones);
    end
  endtask

  task automatic test_reset_mid_dump();
    bit reached = 1'b0;
    int beats = 0;
    int dones = 0;
    dump_ready = 1'b1;
    dump_start = 1'b1;
    clk_step();
    dump_start = 1'b0;
    for (int c = 0; c < 50; c++) begin
      #1;
      if (dump_valid && dump_addr == 5'd10) begin
        reached = 1'b1;
        break;
      end
      clk_step();
    end
    rst_n = 1'b0;
    clk_step();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      vectors++;
      if (!reached || dump_busy !== 1'b0 || dump_valid !== 1'b0 ||
          dump_done !== 1'b0 || dump_addr !== 5'd0) begin
        miscompares++;
        $display("FAIL rst_mid_dump c%0d: got reached=%0b busy=%b valid=%b done=%b addr=%0d want 1/0/0/0/0",
                 c, reached, dump_busy, dump_valid, dump_done, dump_addr);
      end
      clk_step();
    end
    we = 1'b1; waddr = 5'd0; wdata = 8'h3C;
    dump_start = 1'b1;
    clk_step();
    we = 1'b0;
    dump_start = 1'b0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (!dump_busy) break;
      if (dump_valid) begin
        vectors++;
        if (dump_addr !== 5'(beats) || dump_data !== model[beats[4:0]]) begin
          miscompares++;
          $display("FAIL restart_beat%0d: got addr=%0d data=%h want addr=%0d data=%h",
                   beats, dump_addr, dump_data, beats, model[beats[4:0]]);
        end
        beats++;
      end
      if (dump_done) dones++;
      clk_step();
    end
    vectors++;
    if (beats != 32 || dones != 1) begin
      miscompares++;
      $display("FAIL restart_totals: got beats=%0d dones=%0d want 32/1", beats, dones);
    end
  endtask

  task automatic test_random_rw();
    logic [7:0] exp_a, exp_b;
    for (int c = 0; c < 300; c++) begin
      we      = $urandom_range(1, 0) == 1;
      waddr   = 5'($urandom);
      wdata   = 8'($urandom);
      raddr_a = ($urandom_range(3, 0) == 0) ? waddr : 5'($urandom);
      raddr_b = ($urandom_range(3, 0) == 0) ? waddr : 5'($urandom);
      #1;
      exp_a = (BYP && we && waddr == raddr_a) ? wdata : model[raddr_a];
      exp_b = (BYP && we && waddr == raddr_b) ? wdata : model[raddr_b];
      vectors++;
      if (rdata_a !== exp_a || rdata_b !== exp_b) begin
        miscompares++;
        $display("FAIL random_rw c%0d: got a=%h b=%h want a=%h b=%h", c, rdata_a, rdata_b, exp_a, exp_b);
      end
      clk_step();
    end
    we = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model[i] = 8'h00;
    rst_n = 1'b0;
    clk_step();
    clk_step();
    rst_n = 1'b1;
    test_reset();
    test_write_read();
    test_same_cycle();
    test_dump();
    test_backpressure();
    test_reset_mid_dump();
    test_random_rw();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
